// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_XLEN  = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries. A flush empties it and wins over a push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & ~empty;
  assign head    = mem[rd_ptr];

  // Entry storage; no reset needed because count gates what is visible.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: drives a latency-1 instruction BRAM from a byte PC,
// buffers returned words and hands {pc, instr} to the decoder over valid/ready.
// The entry type is fixed at FETCH_XLEN bits, so XLEN is expected to match it.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              ADDR_W     = 7,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_instr,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              misalign_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  inflight_pc_q;
  logic [XLEN-1:0]  last_pc_q;
  logic [XLEN-1:0]  last_instr_q;
  logic             inflight_q;
  logic             inflight_epoch_q;
  logic             epoch_q;
  logic             misalign_q;
  logic             pop;
  logic             push;
  logic             fifo_empty;
  logic [CNT_W-1:0] count;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  int               occupancy;

  assign mem_addr     = pc_q[ADDR_W+1:2];
  assign out_valid    = ~fifo_empty;
  assign out_pc       = out_valid ? head.pc : last_pc_q;
  assign out_instr    = out_valid ? head.instr : last_instr_q;
  assign misalign_err = misalign_q;

  // A returning word is kept only if no redirect has happened since it was issued.
  assign push             = inflight_q & (inflight_epoch_q == epoch_q);
  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = mem_rdata;

  // Issue a read only when the FIFO is guaranteed to have room for its return.
  always_comb begin
    pop       = out_valid & out_ready;
    occupancy = int'(count) + int'(inflight_q) - int'(pop);
    mem_rd_en = ~reset & fetch_en & ~redirect_valid & (occupancy < FIFO_DEPTH);
  end

  // PC advance, redirect with epoch flip, and the sticky misalignment flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      epoch_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q    <= {redirect_pc[XLEN-1:2], 2'b00};
      epoch_q <= ~epoch_q;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_q <= 1'b1;
      end
    end else if (mem_rd_en) begin
      pc_q <= pc_q + XLEN'(INSTR_BYTES);
    end
  end

  // Tag the read in flight with its PC and the epoch it was issued in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
    end else begin
      inflight_q       <= mem_rd_en;
      inflight_pc_q    <= pc_q;
      inflight_epoch_q <= epoch_q;
    end
  end

  // Remember the last presented entry so the outputs hold while the FIFO is empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else if (out_valid) begin
      last_pc_q    <= head.pc;
      last_instr_q <= head.instr;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (count),
    .head     (head),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a behavioural BRAM and a stream-level reference model.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int ADDR_W     = 5;
  localparam int MEM_WORDS  = 1 << ADDR_W;
  localparam int FIFO_DEPTH = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_en = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              misalign_err;

  logic [31:0] bram [MEM_WORDS];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_rd_en;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] exp_pc;
  logic        model_mis;
  logic        hold_pending;
  logic [31:0] held_pc;
  logic [31:0] held_instr;
  int          accepted;
  logic        r_fe;
  logic        r_rdy;
  logic        r_rv;
  logic [31:0] r_pc;

  instr_fetch #(
    .XLEN      (32),
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .misalign_err  (misalign_err)
  );

  always #5 clock = ~clock;

  // Behavioural synchronous-read BRAM, one cycle of read latency.
  always @(posedge clock) begin
    if (mem_rd_en) begin
      mem_rdata <= bram[mem_addr];
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] w(input int n);
    return 32'h1000_0000 + 32'(n);
  endfunction

  // Memory image seen at a byte PC: word index wraps modulo the BRAM depth.
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) % MEM_WORDS);
  endfunction

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic v,
                              input logic [31:0] pc, input logic [31:0] instr,
                              input logic rd, input int addr, input logic mis);
    vec_t t;
    t.fe        = 1'b1;
    t.rdy       = 1'b1;
    t.rv        = rv;
    t.rpc       = rpc;
    t.exp_valid = v;
    t.exp_pc    = pc;
    t.exp_instr = instr;
    t.exp_rd_en = rd;
    t.exp_addr  = 32'(addr);
    t.exp_mis   = mis;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge and move to the sampling point.
  task automatic apply_stimulus(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clock);
  endtask

  task automatic finish_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      bram[i] = w(i);
    end
    fetch_en  = 1'b1;
    out_ready = 1'b1;

    // Reset values while reset is held, even with fetch_en high.
    @(negedge clock);
    check_output("reset_valid", 32'(out_valid), 32'd0);
    check_output("reset_rd_en", 32'(mem_rd_en), 32'd0);
    check_output("reset_addr", 32'(mem_addr), 32'd0);
    check_output("reset_pc", out_pc, 32'd0);
    check_output("reset_instr", out_instr, 32'd0);
    check_output("reset_misalign", 32'(misalign_err), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Streaming from reset, redirect to 0x40 at cycle 6, misaligned redirect 0x22 at cycle 11.
    vecs.push_back(mk(0, 0,     0, 32'h00, 32'h0, 1, 0,  0));
    vecs.push_back(mk(0, 0,     0, 32'h00, 32'h0, 1, 1,  0));
    vecs.push_back(mk(0, 0,     1, 32'h00, w(0),  1, 2,  0));
    vecs.push_back(mk(0, 0,     1, 32'h04, w(1),  1, 3,  0));
    vecs.push_back(mk(0, 0,     1, 32'h08, w(2),  1, 4,  0));
    vecs.push_back(mk(0, 0,     1, 32'h0C, w(3),  1, 5,  0));
    vecs.push_back(mk(1, 32'h40, 1, 32'h10, w(4), 0, 6,  0));
    vecs.push_back(mk(0, 0,     0, 32'h10, w(4),  1, 16, 0));
    vecs.push_back(mk(0, 0,     0, 32'h10, w(4),  1, 17, 0));
    vecs.push_back(mk(0, 0,     1, 32'h40, w(16), 1, 18, 0));
    vecs.push_back(mk(0, 0,     1, 32'h44, w(17), 1, 19, 0));
    vecs.push_back(mk(1, 32'h22, 1, 32'h48, w(18), 0, 20, 0));
    vecs.push_back(mk(0, 0,     0, 32'h48, w(18), 1, 8,  1));
    vecs.push_back(mk(0, 0,     0, 32'h48, w(18), 1, 9,  1));
    vecs.push_back(mk(0, 0,     1, 32'h20, w(8),  1, 10, 1));
    vecs.push_back(mk(0, 0,     1, 32'h24, w(9),  1, 11, 1));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      check_output($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check_output($sformatf("tbl%0d_pc", i), out_pc, vecs[i].exp_pc);
      check_output($sformatf("tbl%0d_instr", i), out_instr, vecs[i].exp_instr);
      check_output($sformatf("tbl%0d_rd_en", i), 32'(mem_rd_en), 32'(vecs[i].exp_rd_en));
      check_output($sformatf("tbl%0d_addr", i), 32'(mem_addr), vecs[i].exp_addr);
      check_output($sformatf("tbl%0d_misalign", i), 32'(misalign_err), 32'(vecs[i].exp_mis));
      finish_cycle();
    end

    // Back-pressure: head held, no new reads once the FIFO is full.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 0, 0, 0);
      check_output("bp_valid", 32'(out_valid), 32'd1);
      check_output("bp_pc", out_pc, 32'h28);
      check_output("bp_instr", out_instr, w(10));
      check_output("bp_rd_en", 32'(mem_rd_en), 32'd0);
      finish_cycle();
    end
    // Release: stream resumes with nothing lost, duplicated or delayed.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 1, 0, 0);
      check_output("rel_valid", 32'(out_valid), 32'd1);
      check_output("rel_pc", out_pc, 32'h28 + 32'(4 * i));
      check_output("rel_instr", out_instr, word_at(32'h28 + 32'(4 * i)));
      finish_cycle();
    end

    // Fill the FIFO, then redirect in the same cycle as a pop.
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, 0, 0, 0);
      check_output("fill_pc", out_pc, 32'h38);
      finish_cycle();
    end
    check_output("fill_rd_en", 32'(mem_rd_en), 32'd0);
    apply_stimulus(1, 1, 1, 32'h78);
    check_output("rdp_valid", 32'(out_valid), 32'd1);
    check_output("rdp_pc", out_pc, 32'h38);
    check_output("rdp_instr", out_instr, word_at(32'h38));
    check_output("rdp_rd_en", 32'(mem_rd_en), 32'd0);
    finish_cycle();
    apply_stimulus(1, 1, 0, 0);
    check_output("rdp1_valid", 32'(out_valid), 32'd0);
    check_output("rdp1_rd_en", 32'(mem_rd_en), 32'd1);
    check_output("rdp1_addr", 32'(mem_addr), 32'd30);
    check_output("rdp1_hold_pc", out_pc, 32'h38);
    finish_cycle();
    apply_stimulus(1, 1, 0, 0);
    check_output("rdp2_valid", 32'(out_valid), 32'd0);
    finish_cycle();
    // Target stream crosses the end of the BRAM and aliases back to word 0.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 1, 0, 0);
      check_output("wrap_valid", 32'(out_valid), 32'd1);
      check_output("wrap_pc", out_pc, 32'h78 + 32'(4 * i));
      check_output("wrap_instr", out_instr, word_at(32'h78 + 32'(4 * i)));
      finish_cycle();
    end

    // Asynchronous reset between edges clears everything at once.
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_output("areset_valid", 32'(out_valid), 32'd0);
    check_output("areset_rd_en", 32'(mem_rd_en), 32'd0);
    check_output("areset_misalign", 32'(misalign_err), 32'd0);
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    apply_stimulus(1, 0, 0, 0);
    check_output("restart0_valid", 32'(out_valid), 32'd0);
    check_output("restart0_rd_en", 32'(mem_rd_en), 32'd1);
    check_output("restart0_addr", 32'(mem_addr), 32'd0);
    finish_cycle();
    apply_stimulus(1, 0, 0, 0);
    check_output("restart1_valid", 32'(out_valid), 32'd0);
    finish_cycle();
    apply_stimulus(1, 0, 0, 0);
    check_output("restart2_valid", 32'(out_valid), 32'd1);
    check_output("restart2_pc", out_pc, 32'h0);
    check_output("restart2_instr", out_instr, w(0));
    finish_cycle();

    // Random traffic against the stream-level model.
    exp_pc       = 32'h0;
    model_mis    = 1'b0;
    hold_pending = 1'b1;
    held_pc      = 32'h0;
    held_instr   = w(0);
    accepted     = 0;
    for (int i = 0; i < 600; i++) begin
      r_fe  = ($urandom_range(0, 99) < 85);
      r_rdy = ($urandom_range(0, 99) < 70);
      r_rv  = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 3) == 0) begin
        r_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      end else begin
        r_pc = 32'($urandom_range(0, 255));
      end
      apply_stimulus(r_fe, r_rdy, r_rv, r_rv ? r_pc : 32'h0);
      if (hold_pending) begin
        check_output("rnd_hold_valid", 32'(out_valid), 32'd1);
        check_output("rnd_hold_pc", out_pc, held_pc);
        check_output("rnd_hold_instr", out_instr, held_instr);
      end
      if (out_valid && out_ready) begin
        check_output("rnd_pc", out_pc, exp_pc);
        check_output("rnd_instr", out_instr, word_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      check_output("rnd_misalign", 32'(misalign_err), 32'(model_mis));
      hold_pending = out_valid && !out_ready && !redirect_valid;
      held_pc      = out_pc;
      held_instr   = out_instr;
      if (r_rv) begin
        exp_pc = {r_pc[31:2], 2'b00};
        if (r_pc[1:0] != 2'b00) begin
          model_mis = 1'b1;
        end
      end
      finish_cycle();
    end
    vectors++;
    if (accepted < 100) begin
      miscompares++;
      $display("[TB] FAIL rnd_progress: got %0d accepted, expected at least 100", accepted);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
